// File: rtl/raxm_mul_arbiter.sv
// -----------------------------------------------------------------------------
// raxm_mul_arbiter
//
// Shares one approximate multiplier (RAxM core, start/done handshake) between
// two requesters: requester 0 is the Wishbone register front end, requester 1
// is the logic-analyzer driver. Requests are granted round-robin, one
// operation at a time. The product (or a timeout abort) is returned to the
// granted requester only.
//
// Handshake semantics (all channels):
//   reqN: the requester raises reqN_valid with stable operands and keeps them
//         until it sees reqN_ready. reqN_ready is a one-cycle accept pulse,
//         only ever raised in IDLE, and only for the requester being granted.
//   rspN: rspN_valid stays high, with rsp_data/rsp_err held, until the
//         requester raises rspN_ready. The transfer happens in the cycle
//         where both are high.
//   mul:  mul_start is a one-cycle pulse; mul_a/mul_b stay stable until the
//         operation completes. mul_done is only looked at while waiting for
//         the result, so stray or late pulses are harmless.
//
// Ports:
//   wb_clk_i, wb_rst_ni          clock, asynchronous active-low reset
//   req{0,1}_valid/ready/a/b     operand request channels
//   rsp{0,1}_valid/ready         response channels
//   rsp_data, rsp_err            shared response payload (product / abort flag)
//   mul_start, mul_a, mul_b      multiplier command
//   mul_done, mul_p              multiplier completion and product
//   busy                         high whenever an operation is in flight
// -----------------------------------------------------------------------------
module raxm_mul_arbiter #(
    parameter int WIDTH   = 16,
    parameter int TIMEOUT = 15   // WAIT cycles before abort, 1..255
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_ni,

    input  logic               req0_valid,
    output logic               req0_ready,
    input  logic [WIDTH-1:0]   req0_a,
    input  logic [WIDTH-1:0]   req0_b,
    output logic               rsp0_valid,
    input  logic               rsp0_ready,

    input  logic               req1_valid,
    output logic               req1_ready,
    input  logic [WIDTH-1:0]   req1_a,
    input  logic [WIDTH-1:0]   req1_b,
    output logic               rsp1_valid,
    input  logic               rsp1_ready,

    output logic [2*WIDTH-1:0] rsp_data,
    output logic               rsp_err,

    output logic               mul_start,
    output logic [WIDTH-1:0]   mul_a,
    output logic [WIDTH-1:0]   mul_b,
    input  logic               mul_done,
    input  logic [2*WIDTH-1:0] mul_p,

    output logic               busy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    state_t     state;
    state_t     state_nxt;

    logic       grant;        // requester owning the current operation
    logic       last_grant;   // requester served most recently
    logic [7:0] timer;        // WAIT cycles already spent without done

    logic       arb_any;
    logic       arb_sel;
    logic       wait_expired;
    logic       rsp_taken;

    // Round-robin pick: a lone requester always wins; on a tie the one that
    // was not served last wins. last_grant resets to 1 so requester 0 wins
    // the first tie after reset.
    always_comb begin
        arb_any = req0_valid | req1_valid;
        if (req0_valid && req1_valid) begin
            arb_sel = ~last_grant;
        end else begin
            arb_sel = req1_valid;
        end
    end

    // timer counts completed WAIT cycles, so this is the TIMEOUT-th WAIT
    // cycle. mul_done is checked first, so done wins a same-cycle tie.
    assign wait_expired = (timer == 8'(TIMEOUT - 1));
    assign rsp_taken    = grant ? rsp1_ready : rsp0_ready;

    // State register
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (arb_any) state_nxt = ST_ISSUE;
            ST_ISSUE: state_nxt = ST_WAIT;
            ST_WAIT:  if (mul_done || wait_expired) state_nxt = ST_RESP;
            ST_RESP:  if (rsp_taken) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        rsp0_valid = 1'b0;
        rsp1_valid = 1'b0;
        mul_start  = 1'b0;
        busy       = (state != ST_IDLE);
        case (state)
            ST_IDLE: begin
                req0_ready = arb_any & ~arb_sel;
                req1_ready = arb_any &  arb_sel;
            end
            ST_ISSUE: mul_start = 1'b1;
            ST_RESP: begin
                rsp0_valid = ~grant;
                rsp1_valid =  grant;
            end
            default: ;
        endcase
    end

    // Operand, grant, timer and response registers
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            grant      <= 1'b0;
            last_grant <= 1'b1;
            mul_a      <= '0;
            mul_b      <= '0;
            timer      <= '0;
            rsp_data   <= '0;
            rsp_err    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (arb_any) begin
                        grant <= arb_sel;
                        mul_a <= arb_sel ? req1_a : req0_a;
                        mul_b <= arb_sel ? req1_b : req0_b;
                    end
                end
                ST_ISSUE: timer <= '0;
                ST_WAIT: begin
                    if (mul_done) begin
                        rsp_data <= mul_p;
                        rsp_err  <= 1'b0;
                    end else if (wait_expired) begin
                        rsp_data <= '0;
                        rsp_err  <= 1'b1;
                    end else begin
                        timer <= timer + 8'd1;
                    end
                end
                ST_RESP: begin
                    if (rsp_taken) last_grant <= grant;
                end
                default: ;
            endcase
        end
    end

endmodule
